// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD count-down timer.
package bcd_timer_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_t;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD decade of the count-down chain: loadable, decrements when enabled and borrowed into.
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               en,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out,
    output logic               is_zero
);

    logic [DIGIT_W-1:0] digit_q;

    assign digit      = digit_q;
    assign is_zero    = (digit_q == '0);
    assign borrow_out = borrow_in & is_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else if (load) begin
            digit_q <= load_val;
        end else if (en && borrow_in) begin
            digit_q <= is_zero ? BCD_MAX : digit_q - 1'b1;
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD count-down timer with start/pause control and terminal-count flag.
// Optional periodic reload when BCD_TIMER_AUTORELOAD_EN is defined.
module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000000
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic                  StartStop,
    input  logic [4*DIGITS-1:0]   Preset,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  Running,
    output logic                  Done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t                state_q;
    logic [PW-1:0]         presc_q;
    logic                  running_q;
    logic                  done_q;

    logic [4*DIGITS-1:0]   preset_sat;
    logic [4*DIGITS-1:0]   load_val;
    logic                  digit_load;
    logic [DIGITS:0]       borrow;
    logic [DIGITS-1:0]     dig_zero;
    logic                  borrow_unused;
    logic                  tick;
    logic                  q_zero;
    logic                  q_is_one;

    always_comb begin
        preset_sat = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            preset_sat[i*4 +: 4] = sat_digit(Preset[i*4 +: 4]);
        end
    end

    assign tick     = (state_q == StRun) && (presc_q == PRESC_LAST);
    assign q_zero   = &dig_zero;
    // A count of one is the only value whose decrement lands on zero.
    assign q_is_one = (Q == (4*DIGITS)'(1));

`ifdef BCD_TIMER_AUTORELOAD_EN
    logic [4*DIGITS-1:0] reload_q;
    logic                reload_now;

    assign reload_now = tick && q_is_one && (reload_q != '0) && !Load;
    assign digit_load = Load | reload_now;
    assign load_val   = Load ? preset_sat : reload_q;
`else
    assign digit_load = Load;
    assign load_val   = preset_sat;
`endif

    assign borrow[0]     = 1'b1;
    assign borrow_unused = borrow[DIGITS];

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        bcd_digit_down u_digit (
            .clk        (Clock),
            .rst        (Clear),
            .load       (digit_load),
            .load_val   (load_val[g*4 +: 4]),
            .en         (tick),
            .borrow_in  (borrow[g]),
            .digit      (Q[g*4 +: 4]),
            .borrow_out (borrow[g+1]),
            .is_zero    (dig_zero[g])
        );
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_q  <= '0;
`endif
        end else if (Load) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_q  <= preset_sat;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (StartStop && !q_zero) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StRun: begin
                    done_q <= 1'b0;
                    if (tick) begin
                        presc_q <= '0;
                        if (q_is_one) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
                            if (reload_q != '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q   <= StDone;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
`else
                            state_q   <= StDone;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
`endif
                        end else if (StartStop) begin
                            state_q   <= StPause;
                            running_q <= 1'b0;
                        end
                    end else if (StartStop) begin
                        // Prescaler freezes on the pausing edge so resume continues where it left off.
                        state_q   <= StPause;
                        running_q <= 1'b0;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                StPause: begin
                    if (StartStop) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StDone: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q   <= StIdle;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign Running = running_q;
    assign Done    = done_q;

endmodule
